adc_pulse_reader: RTL
=====================

# adc_pulse_reader

Receive-side counterpart of the DAC pulse path. Takes one 256-bit ADC word per cycle: 16 signed 16-bit samples, with the returning optical pulse occupying a window in the middle of the word. The block integrates the samples inside a GPIO-programmable window, scales the sum and saturates it to a signed `num_bits` value for the Ising core. It is fully pipelined at one word per cycle and sits between the ADC capture interface and the spin-update logic.

## Interface
Parameters:
- `win_start_reg`, default 0: GPIO address of the window-start register.
- `win_len_reg`, default 0: GPIO address of the window-length register.
- `shift_reg`, default 0: GPIO address of the right-shift register.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `adc_word_in`  in  256  16 samples; sample i = bits [16i+15:16i], signed two's complement.
- `adc_word_valid`  in  1  `adc_word_in` is valid this cycle.
- `gpio_in`  in  32  GPIO bus; [15:0] address, [23:16] data, [24] write strobe `w_clk`.
- `val_out`  out  `num_bits`  signed integrated value.
- `val_out_valid`  out  1  `val_out` is valid this cycle.

## Operation
- Config registers, written on a detected rising edge of `gpio_in[24]` when `gpio_in[15:0]` matches the register address.
  - Edge detection uses a registered copy of bit 24.
  - Data is taken from `gpio_in[23:16]`, low bits used.
  - `win_start`: 4 bits, reset value 4.
  - `win_len`: 5 bits, reset value 8. Values above 16 are clamped to 16.
  - `shift`: 5 bits, reset value 3.
  - If parameter addresses coincide, every matching register is written.
- Window mask: sample i is included iff `win_start` ≤ i < `win_start` + `win_len` and i ≤ 15.
  - A window running past sample 15 is truncated.
  - `win_len` = 0 gives a sum of 0.
  - Excluded samples are forced to 0.
- Sum: signed, 20 bits wide. The maximum |sum| is 16·32768 = 2^19, so it never overflows.
- Scale: arithmetic right shift of the sum by `shift`, rounding toward −∞.
- Saturate to signed `num_bits`:
  - above 2^(num_bits−1)−1 → max;
  - below −2^(num_bits−1) → min.
- Pipeline stages, one register level each:
  - S1: mask the samples. Config is sampled here.
  - S2: four 4-input partial sums.
  - S3: final sum.
  - S4: shift and saturate into `val_out`.
- Valid travels alongside the data. Invalid input words still propagate with valid low; their data is don't-care.

## Timing
- Reset state, one cycle after `rst` is sampled high:
  - `val_out` = 0 and `val_out_valid` = 0;
  - all pipeline valids are 0;
  - config registers return to their reset values;
  - the `w_clk` history register is cleared.
- Reset mid-stream: all in-flight words are discarded and none appear at the output afterwards.
- Latency: a word presented in cycle N appears in cycle N+4.
- Throughput: one word per cycle, with no back-pressure. Gaps in `adc_word_valid` produce matching gaps in `val_out_valid`.
- `val_out` holds its last value while valid is low.
- Config write timing:
  - A `w_clk` rising edge sampled in cycle N updates the register at the end of cycle N+1.
  - It applies to words entering S1 from cycle N+2 onward.
  - Words already in S2–S4 are unaffected.
- A config write and a valid word in the same cycle is legal. That word uses the old config.
- A `w_clk` held high produces one write only.

## Structure
- `ising_config` package:
  - `num_bits` (existing);
  - new constants `adc_samples` = 16, `adc_sample_w` = 16, `adc_sum_w` = 20;
  - reset values for `win_start`, `win_len` and `shift`.
- Sub-module `gpio_cfg_reg`: one GPIO-addressed register with `w_clk` edge detection and a reset value. It is instantiated three times (`win_start`, `win_len`, `shift`) and is reusable by other GPIO-configured blocks.

## Test plan
Test cases use `num_bits` = 8.
- **Defaults:** samples 4..11 = 100, all others = 1000. Expect `val_out` = 100 (800 >> 3) with valid 4 cycles later.
- **Saturation:** all samples 0x7FFF gives 127; all samples 0x8000 gives −128. Window −5 in samples 4..11 gives −40 >> 3 = −5.
- **GPIO reconfiguration:** write start = 0, len = 16, shift = 4, then send all samples = 16. Expect 256 >> 4 = 16. Write start = 14, len = 8 with samples 14,15 = 40 and others 0: expect 80 >> 4 = 5 (truncated window). len = 0 gives 0.
- **Streaming:** 20 back-to-back words with ramp values, then a 3-cycle valid gap, then 5 more words. Output valids match the input pattern delayed by 4 cycles, in order, each value correct.
- **Config race:** a write edge in the same cycle as word A and the next cycle as word B. A uses the old config. B uses the old config (the update lands at the end of cycle N+1). The word at N+2 uses the new config. `w_clk` held high for 10 cycles gives a single write.
- **Mid-stream reset:** `rst` pulsed for 1 cycle while 3 words are in flight. Outputs drop to 0 and valid low the following cycle, no stale outputs emerge, and config is back at defaults.

Source files
------------

// File: rtl/adc_pulse_reader_pkg.sv
// Shared Ising-core sizing plus the ADC integration constants and config reset values.
package ising_config;

    localparam int num_bits     = 8;
    localparam int adc_samples  = 16;
    localparam int adc_sample_w = 16;
    localparam int adc_sum_w    = 20;

    localparam logic [3:0] win_start_rst = 4'd4;
    localparam logic [4:0] win_len_rst   = 5'd8;
    localparam logic [4:0] shift_rst     = 5'd3;

    typedef logic signed [adc_sample_w-1:0] sample_t;
    typedef logic signed [adc_sum_w-1:0]    sum_t;
    typedef logic signed [num_bits-1:0]     val_t;

    localparam sum_t sum_max = sum_t'((2 ** (num_bits - 1)) - 1);
    localparam sum_t sum_min = sum_t'(-(2 ** (num_bits - 1)));

    function automatic val_t sat_to_val(input sum_t v);
        if (v > sum_max) return val_t'(sum_max);
        if (v < sum_min) return val_t'(sum_min);
        return val_t'(v);
    endfunction

endpackage

// File: rtl/adc_pulse_reader_gpio_cfg_reg.sv
// One GPIO-addressed config register, written once per rising edge of the w_clk strobe.
module gpio_cfg_reg #(
    parameter logic [15:0] addr    = 16'd0,
    parameter int          width   = 4,
    parameter logic [width-1:0] rst_val = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       gpio_in,
    output logic [width-1:0]  value
);

    logic [15:0]      addr_q;
    logic [width-1:0] data_q;
    logic             w_clk_q;
    logic             w_clk_hist;
    logic             write;
    logic             unused_bits;

    assign unused_bits = &{1'b0, gpio_in};

    // Bus is registered first, so the edge seen here is one cycle after it was sampled.
    assign write = w_clk_q & ~w_clk_hist & (addr_q == addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            data_q     <= '0;
            w_clk_q    <= 1'b0;
            w_clk_hist <= 1'b0;
            value      <= rst_val;
        end else begin
            addr_q     <= gpio_in[15:0];
            data_q     <= gpio_in[16 +: width];
            w_clk_q    <= gpio_in[24];
            w_clk_hist <= w_clk_q;
            if (write) value <= data_q;
        end
    end

endmodule

// File: rtl/adc_pulse_reader.sv
// Windowed integration of 16 ADC samples per word, scaled and saturated for the Ising core.
module adc_pulse_reader
    import ising_config::*;
#(
    parameter logic [15:0] win_start_reg = 16'd0,
    parameter logic [15:0] win_len_reg   = 16'd0,
    parameter logic [15:0] shift_reg     = 16'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [255:0]               adc_word_in,
    input  logic                       adc_word_valid,
    input  logic [31:0]                gpio_in,
    output logic signed [num_bits-1:0] val_out,
    output logic                       val_out_valid
);

    logic [3:0] win_start;
    logic [4:0] win_len;
    logic [4:0] shift;

    gpio_cfg_reg #(.addr(win_start_reg), .width(4), .rst_val(win_start_rst)) u_win_start (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .value(win_start));
    gpio_cfg_reg #(.addr(win_len_reg), .width(5), .rst_val(win_len_rst)) u_win_len (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .value(win_len));
    gpio_cfg_reg #(.addr(shift_reg), .width(5), .rst_val(shift_rst)) u_shift (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .value(shift));

    logic [5:0]           len_eff;
    logic [5:0]           win_end;
    sample_t              masked [adc_samples];

    sample_t              s1_data [adc_samples];
    logic [4:0]           s1_shift;
    logic                 s1_valid;
    logic signed [17:0]   part [4];
    logic signed [17:0]   s2_part [4];
    logic [4:0]           s2_shift;
    logic                 s2_valid;
    sum_t                 sum;
    sum_t                 s3_sum;
    logic [4:0]           s3_shift;
    logic                 s3_valid;
    sum_t                 scaled;

    assign len_eff = (win_len > 5'd16) ? 6'd16 : {1'b0, win_len};
    assign win_end = {2'b00, win_start} + len_eff;

    always_comb begin
        for (int i = 0; i < adc_samples; i++) begin
            masked[i] = '0;
            if (6'(i) >= {2'b00, win_start} && 6'(i) < win_end)
                masked[i] = sample_t'(adc_word_in[16*i +: 16]);
        end
    end

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            part[g] = '0;
            part[g] = s1_data[4*g] + s1_data[4*g+1] + s1_data[4*g+2] + s1_data[4*g+3];
        end
    end

    assign sum    = s2_part[0] + s2_part[1] + s2_part[2] + s2_part[3];
    assign scaled = s3_sum >>> s3_shift;

    // Shift travels with its word so a later config write never retimes in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < adc_samples; i++) s1_data[i] <= '0;
            for (int g = 0; g < 4; g++) s2_part[g] <= '0;
            s1_shift      <= '0;
            s1_valid      <= 1'b0;
            s2_shift      <= '0;
            s2_valid      <= 1'b0;
            s3_sum        <= '0;
            s3_shift      <= '0;
            s3_valid      <= 1'b0;
            val_out       <= '0;
            val_out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < adc_samples; i++) s1_data[i] <= masked[i];
            s1_shift <= shift;
            s1_valid <= adc_word_valid;
            for (int g = 0; g < 4; g++) s2_part[g] <= part[g];
            s2_shift <= s1_shift;
            s2_valid <= s1_valid;
            s3_sum   <= sum;
            s3_shift <= s2_shift;
            s3_valid <= s2_valid;
            if (s3_valid) val_out <= sat_to_val(scaled);
            val_out_valid <= s3_valid;
        end
    end

endmodule
